// File: rtl/y86_decode_regfile_if.sv
// Decode-stage bus: instruction in, two writeback ports, registered decode out.
interface y86_decode_regfile_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              stall;
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              wE_en;
  logic [3:0]        dstE;
  logic [DATA_W-1:0] valE;
  logic              wM_en;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valM;
  logic              out_valid;
  logic [3:0]        out_icode;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;

  modport master (
    output in_valid, stall, icode, rA, rB,
    output wE_en, dstE, valE, wM_en, dstM, valM,
    input  out_valid, out_icode, srcA, srcB, valA, valB
  );

  modport slave (
    input  in_valid, stall, icode, rA, rB,
    input  wE_en, dstE, valE, wM_en, dstM, valM,
    output out_valid, out_icode, srcA, srcB, valA, valB
  );
endinterface

// File: rtl/y86_decode_regfile.sv
// Y86-64 decode stage: register file with E/M writeback, source select and
// a stallable output register. Read ports are replicated per operand.
module y86_rd_port #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int BYPASS = 1
) (
  input  logic [3:0]                   src,
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic                         wE_en,
  input  logic [3:0]                   dstE,
  input  logic [DATA_W-1:0]            valE,
  input  logic                         wM_en,
  input  logic [3:0]                   dstM,
  input  logic [DATA_W-1:0]            valM,
  output logic [DATA_W-1:0]            val
);
  logic in_rng;

  always_comb begin
    in_rng = (src < 4'(NREGS));
    val    = '0;
    for (int i = 0; i < NREGS; i++)
      if (src == 4'(i)) val = regs[i];
    // M is checked last so it wins when both ports hit the same register
    if (BYPASS != 0) begin
      if (in_rng && wE_en && (dstE == src)) val = valE;
      if (in_rng && wM_en && (dstM == src)) val = valM;
    end
  end
endmodule

module y86_decode_regfile #(
  parameter int DATA_W  = 64,
  parameter int NREGS   = 15,
  parameter int RSP_IDX = 4,
  parameter int BYPASS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  y86_decode_regfile_if.slave  bus
);
  localparam int         NRD   = 2;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP  = 4'h1;

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
  } dec_out_t;

  localparam dec_out_t OUT_BUBBLE = '{icode: INOP, srcA: RNONE, srcB: RNONE,
                                      valA: '0, valB: '0};

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NRD-1:0][3:0]          src_sel;
  logic [NRD-1:0][DATA_W-1:0]   rd_val;
  dec_out_t                     out_q, out_d;
  logic                         out_valid_q, out_valid_d;

  // Operand A (index 0) and operand B (index 1) source selection
  always_comb begin
    src_sel[0] = RNONE;
    src_sel[1] = RNONE;
    case (bus.icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_sel[0] = bus.rA;
      4'h9, 4'hB:             src_sel[0] = 4'(RSP_IDX);
      default:                src_sel[0] = RNONE;
    endcase
    case (bus.icode)
      4'h4, 4'h5, 4'h6:       src_sel[1] = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_sel[1] = 4'(RSP_IDX);
      default:                src_sel[1] = RNONE;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_rd
      y86_rd_port #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
      ) u_rd (
        .src   (src_sel[g]),
        .regs  (regs_q),
        .wE_en (bus.wE_en),
        .dstE  (bus.dstE),
        .valE  (bus.valE),
        .wM_en (bus.wM_en),
        .dstM  (bus.dstM),
        .valM  (bus.valM),
        .val   (rd_val[g])
      );
    end
  endgenerate

  // Writeback ignores stall/in_valid; out-of-range destinations match nothing
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.wE_en && (bus.dstE == 4'(i))) regs_d[i] = bus.valE;
      if (bus.wM_en && (bus.dstM == 4'(i))) regs_d[i] = bus.valM;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (!bus.stall) begin
      if (bus.in_valid) begin
        out_d.icode = bus.icode;
        out_d.srcA  = src_sel[0];
        out_d.srcB  = src_sel[1];
        out_d.valA  = rd_val[0];
        out_d.valB  = rd_val[1];
        out_valid_d = 1'b1;
      end else begin
        out_d       = OUT_BUBBLE;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      out_q       <= OUT_BUBBLE;
      out_valid_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_icode = out_q.icode;
  assign bus.srcA      = out_q.srcA;
  assign bus.srcB      = out_q.srcB;
  assign bus.valA      = out_q.valA;
  assign bus.valB      = out_q.valB;
endmodule

// File: tb/tb_y86_decode_regfile.sv
// Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus and
// checks both against an array-based architectural model.
module tb_y86_decode_regfile;
  localparam int DW = 64;
  localparam int NR = 15;
  localparam int SP = 4;

  typedef logic [2*DW+12:0] obs_t;  // {valid, icode, srcA, srcB, valA, valB}

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid, stall, wE_en, wM_en;
  logic [3:0]    icode, rA, rB, dstE, dstM;
  logic [DW-1:0] valE, valM;

  logic [DW-1:0] m_regs [16];
  obs_t          expv [2];
  obs_t          obs  [2];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  y86_decode_regfile_if #(.DATA_W(DW)) bus1 ();
  y86_decode_regfile_if #(.DATA_W(DW)) bus0 ();

  assign bus1.in_valid = in_valid;  assign bus0.in_valid = in_valid;
  assign bus1.stall    = stall;     assign bus0.stall    = stall;
  assign bus1.icode    = icode;     assign bus0.icode    = icode;
  assign bus1.rA       = rA;        assign bus0.rA       = rA;
  assign bus1.rB       = rB;        assign bus0.rB       = rB;
  assign bus1.wE_en    = wE_en;     assign bus0.wE_en    = wE_en;
  assign bus1.dstE     = dstE;      assign bus0.dstE     = dstE;
  assign bus1.valE     = valE;      assign bus0.valE     = valE;
  assign bus1.wM_en    = wM_en;     assign bus0.wM_en    = wM_en;
  assign bus1.dstM     = dstM;      assign bus0.dstM     = dstM;
  assign bus1.valM     = valM;      assign bus0.valM     = valM;

  assign obs[1] = {bus1.out_valid, bus1.out_icode, bus1.srcA, bus1.srcB, bus1.valA, bus1.valB};
  assign obs[0] = {bus0.out_valid, bus0.out_icode, bus0.srcA, bus0.srcB, bus0.valA, bus0.valB};

  y86_decode_regfile #(.DATA_W(DW), .NREGS(NR), .RSP_IDX(SP), .BYPASS(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1));
  y86_decode_regfile #(.DATA_W(DW), .NREGS(NR), .RSP_IDX(SP), .BYPASS(0)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0));

  function automatic obs_t rst_val();
    return {1'b0, 4'h1, 4'hF, 4'hF, {DW{1'b0}}, {DW{1'b0}}};
  endfunction

  function automatic logic [3:0] sel_a(input logic [3:0] ic, input logic [3:0] r);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return r;
    if (ic inside {4'h9, 4'hB}) return 4'(SP);
    return 4'hF;
  endfunction

  function automatic logic [3:0] sel_b(input logic [3:0] ic, input logic [3:0] r);
    if (ic inside {4'h4, 4'h5, 4'h6}) return r;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'(SP);
    return 4'hF;
  endfunction

  // Value a read sees this cycle: the stored value, or the incoming write
  // (M preferred) when the instance forwards.
  function automatic logic [DW-1:0] rd(input logic [3:0] s, input bit byp);
    if (int'(s) >= NR) return '0;
    if (byp && wM_en && dstM == s) return valM;
    if (byp && wE_en && dstE == s) return valE;
    return m_regs[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    expv[0] = rst_val();
    expv[1] = rst_val();
  endtask

  // Advance one clock, updating the model with what the edge should do.
  task automatic step();
    logic [3:0] sa, sb;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!stall) begin
        sa = sel_a(icode, rA);
        sb = sel_b(icode, rB);
        for (int k = 0; k < 2; k++)
          expv[k] = in_valid ? {1'b1, icode, sa, sb, rd(sa, k == 1), rd(sb, k == 1)} : rst_val();
      end
      if (wE_en && int'(dstE) < NR) m_regs[dstE] = valE;
      if (wM_en && int'(dstM) < NR) m_regs[dstM] = valM;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
    wE_en = 0; dstE = 4'hF; valE = '0; wM_en = 0; dstM = 4'hF; valM = '0;
  endtask

  task automatic instr(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
    in_valid = 1; icode = ic; rA = a; rB = b;
  endtask

  task automatic test_reset();
    idle();
    wE_en = 1; dstE = 4'h2; valE = 64'h55;
    #1 rst_n = 0;
    #2;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== rst_val()) begin
        bad++; $display("FAIL reset_async byp%0d got=%h want=%h", k, obs[k], rst_val());
      end
    end
    step();
    rst_n = 1;
    idle();
    instr(4'h6, 4'h2, 4'h3);
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== {1'b1, 4'h6, 4'h2, 4'h3, {DW{1'b0}}, {DW{1'b0}}}) begin
        bad++; $display("FAIL reset_read byp%0d got=%h", k, obs[k]);
      end
    end
  endtask

  task automatic test_write_opq();
    idle();
    wE_en = 1; dstE = 4'h2; valE = 64'h11;
    wM_en = 1; dstM = 4'h3; valM = 64'h22;
    step();
    idle();
    instr(4'h6, 4'h2, 4'h3);
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== expv[k] || obs[k][2*DW-1:0] !== {64'h11, 64'h22}) begin
        bad++; $display("FAIL write_opq byp%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    wE_en = 1; dstE = 4'h5; valE = 64'hAA;
    wM_en = 1; dstM = 4'h5; valM = 64'hBB;
    instr(4'h2, 4'h5, 4'h0);
    step();
    total++;
    if (bus1.valA !== 64'hBB || obs[1] !== expv[1]) begin
      bad++; $display("FAIL bypass_on got=%h want=%h", bus1.valA, 64'hBB);
    end
    total++;
    if (bus0.valA !== 64'h0 || obs[0] !== expv[0]) begin
      bad++; $display("FAIL bypass_off got=%h want=%h", bus0.valA, 64'h0);
    end
    idle();
    instr(4'h2, 4'h5, 4'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== expv[k] || obs[k][2*DW-1:DW] !== 64'hBB) begin
        bad++; $display("FAIL bypass_reg5 byp%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_stack();
    idle();
    wE_en = 1; dstE = 4'h4; valE = 64'h100;
    wM_en = 1; dstM = 4'h1; valM = 64'h7;
    step();
    idle();
    instr(4'h9, 4'h0, 4'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== {1'b1, 4'h9, 4'h4, 4'h4, 64'h100, 64'h100}) begin
        bad++; $display("FAIL stack_ret byp%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    instr(4'hA, 4'h1, 4'hF);
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== {1'b1, 4'hA, 4'h1, 4'h4, 64'h7, 64'h100}) begin
        bad++; $display("FAIL stack_push byp%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_stall();
    idle();
    instr(4'h2, 4'h1, 4'h0);
    step();
    stall = 1;
    instr(4'h6, 4'h1, 4'h4);
    wE_en = 1; dstE = 4'h1; valE = 64'h9;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== expv[k] || obs[k] !== {1'b1, 4'h2, 4'h1, 4'hF, 64'h7, 64'h0}) begin
          bad++; $display("FAIL stall_hold c%0d byp%0d got=%h want=%h", c, k, obs[k], expv[k]);
        end
      end
    end
    idle();
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== rst_val()) begin
        bad++; $display("FAIL stall_release byp%0d got=%h want=%h", k, obs[k], rst_val());
      end
    end
    instr(4'h2, 4'h1, 4'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== expv[k] || obs[k][2*DW-1:DW] !== 64'h9) begin
        bad++; $display("FAIL stall_write byp%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_edge();
    idle();
    instr(4'h6, 4'hF, 4'h2);
    wE_en = 1; dstE = 4'hF; valE = 64'hDEAD;
    wM_en = 1; dstM = 4'hF; valM = 64'hBEEF;
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== expv[k] || obs[k][2*DW-1:DW] !== 64'h0) begin
        bad++; $display("FAIL edge_rnone byp%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    idle();
    for (int r = 0; r < 15; r++) begin
      instr(4'h6, 4'(r), 4'(14 - r));
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== expv[k]) begin
          bad++; $display("FAIL edge_regs r%0d byp%0d got=%h want=%h", r, k, obs[k], expv[k]);
        end
      end
    end
    instr(4'h6, 4'h2, 4'h3);
    step();
    stall = 1;
    wE_en = 1; dstE = 4'h2; valE = 64'h77;
    step();
    #2 rst_n = 0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== rst_val()) begin
        bad++; $display("FAIL edge_rst_mid_stall byp%0d got=%h want=%h", k, obs[k], rst_val());
      end
    end
    step();
    rst_n = 1;
    idle();
    instr(4'h6, 4'h2, 4'h3);
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== {1'b1, 4'h6, 4'h2, 4'h3, 64'h0, 64'h0}) begin
        bad++; $display("FAIL edge_after_rst byp%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      icode    = 4'($urandom_range(0, 15));
      rA       = 4'($urandom_range(0, 15));
      rB       = 4'($urandom_range(0, 15));
      wE_en    = $urandom_range(0, 1) == 1;
      dstE     = 4'($urandom_range(0, 15));
      valE     = {$urandom, $urandom};
      wM_en    = $urandom_range(0, 1) == 1;
      dstM     = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
      valM     = {$urandom, $urandom};
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== expv[k]) begin
          bad++; $display("FAIL random c%0d byp%0d got=%h want=%h", c, k, obs[k], expv[k]);
        end
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_write_opq();
    test_bypass();
    test_stack();
    test_stall();
    test_edge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
